des_linear_scheduler: RTL
=========================

// Module: des_linear_scheduler
// PURPOSE
//  Sequences one des_encryption_unroll4 core over a batch of plaintexts under one fixed key schedule.
//  Per result, evaluates a linear approximation parity(P&mask_in) ^ parity(C&mask_out) and counts hits (==0).
//  Sits between the host/test logic and the DES core; owns the core's start/message/round_keys inputs.
// PARAMETERS
//  CNT_W  32  width of nb_messages, issued and count
// PORTS
//  clk              in   1      system clock, all logic on posedge
//  rst_n            in   1      asynchronous active-low reset
//  go               in   1      start batch; sampled in IDLE only
//  abort            in   1      stop batch early; sampled while busy
//  base_message     in   [1:64] first plaintext / LFSR seed
//  nb_messages      in   CNT_W  number of encryptions in batch
//  round_keys_in    in   [1:768] 16x48-bit round keys
//  mask_in          in   [1:64] plaintext parity mask
//  mask_out         in   [1:64] ciphertext parity mask
//  core_start       out  1      to core start
//  core_message     out  [1:64] to core message
//  core_round_keys  out  [1:768] to core round_keys
//  core_done        in   1      from core done
//  core_result      in   [1:64] from core result
//  busy             out  1      batch in progress
//  done             out  1      one-cycle pulse at batch end
//  aborted          out  1      last batch ended by abort; held until next go
//  issued           out  CNT_W  encryptions completed in current/last batch
//  count            out  CNT_W  approximation hits in current/last batch
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal latches 0.
//  States: IDLE -> ISSUE -> WAIT -> (ISSUE | FINISH) -> IDLE.
//  IDLE: on go: latch base_message, nb_messages, round_keys_in, masks; clear issued, count, aborted;
//    busy=1 next cycle. If nb_messages==0 go to FINISH directly (no core_start).
//  ISSUE: core_start=1 for exactly one cycle; core_message = current plaintext; -> WAIT.
//  WAIT: hold core_message/core_round_keys stable; on core_done=1 sample core_result that cycle:
//    count += (parity(msg&mask_in) ^ parity(result&mask_out)) == 0; issued += 1;
//    if issued+1 == nb_messages or abort_pending -> FINISH, else advance plaintext -> ISSUE.
//  FINISH: done=1 one cycle, busy=0 from next cycle, -> IDLE. issued/count/aborted hold until next go.
//  Next core_start never earlier than cycle after core_done; at most one encryption in flight.
//  Per message: 1 ISSUE cycle + core latency. core_round_keys driven from latch at all times.
//  Plaintext advance: 64-bit unsigned +1, bit 64 = LSB, bit 1 = MSB; FFFF_FFFF_FFFF_FFFF wraps to 0.
//  abort in ISSUE/WAIT sets abort_pending; in-flight encryption still completes and is counted;
//    then FINISH with aborted=1. abort in IDLE/FINISH ignored. abort and last core_done same cycle -> aborted=1.
//  go while busy ignored (no relatch). core_done outside WAIT ignored.
//  Counters saturate never needed: issued <= nb_messages < 2^CNT_W.
//  Reset mid-batch: immediate return to IDLE, core_start=0, counts cleared; core output discarded.
// CONFIGURATION
//  DES_LFSR_MSG_EN defined: plaintext advance is Fibonacci LFSR, taps 64,63,61,60 (x^64+x^63+x^61+x^60+1),
//    shift toward bit 64, feedback into bit 1; zero seed replaced by 64'h1 at latch.
//  Undefined: counter advance as above. Both: first message = base_message (or 1 for zero seed w/ LFSR).
// TESTING
//  T1 keys of 133457799BBCDFF1, base 0123456789ABCDEF, nb=1, masks 0 -> one core_start, result
//     85E813540F0AB405 seen, done pulse, issued=1, count=1, aborted=0.
//  T2 nb=0, go -> done within 2 cycles, no core_start, issued=0, count=0, busy never stays high.
//  T3 nb=1000, masks 0, base 0 -> exactly 1000 core_start pulses, messages 0..999, count=1000.
//  T4 base FFFF_FFFF_FFFF_FFFE, nb=4, mask_in=bit 64 only, mask_out=0 -> messages FFFE,FFFF,0,1 (wrap),
//     count=2, issued=4.
//  T5 nb=100, abort pulsed during 10th WAIT, go pulsed mid-batch -> done after 10th core_done,
//     issued=10, aborted=1, base not relatched.
//  T6 rst_n low during WAIT of 5th message -> all outputs 0 same cycle; after release, go runs T1 cleanly.

Source files
------------

// File: rtl/des_linear_scheduler.sv
// Batch sequencer for one DES core that scores a linear approximation over every result.
// Define DES_LFSR_MSG_EN to advance plaintexts with a 64-bit LFSR instead of a +1 counter.
module des_linear_scheduler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [1:64]      base_message,
    input  logic [CNT_W-1:0] nb_messages,
    input  logic [1:768]     round_keys_in,
    input  logic [1:64]      mask_in,
    input  logic [1:64]      mask_out,
    output logic             core_start,
    output logic [1:64]      core_message,
    output logic [1:768]     core_round_keys,
    input  logic             core_done,
    input  logic [1:64]      core_result,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t           state;
    logic [1:64]      msg_q;
    logic [1:64]      mask_in_q;
    logic [1:64]      mask_out_q;
    logic [1:768]     keys_q;
    logic [CNT_W-1:0] nb_q;
    logic             abort_pending;

    logic [1:64]      seed;
    logic [1:64]      next_msg;
    logic             hit;
    logic             last;

`ifdef DES_LFSR_MSG_EN
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed     = (base_message == 64'h0) ? 64'h1 : base_message;
    assign next_msg = {msg_q[64] ^ msg_q[63] ^ msg_q[61] ^ msg_q[60], msg_q[1:63]};
`else
    assign seed     = base_message;
    assign next_msg = msg_q + 64'd1;
`endif

    assign hit  = ~((^(msg_q & mask_in_q)) ^ (^(core_result & mask_out_q)));
    assign last = (issued + CNT_W'(1)) == nb_q;

    assign core_message    = msg_q;
    assign core_round_keys = keys_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            msg_q         <= '0;
            mask_in_q     <= '0;
            mask_out_q    <= '0;
            keys_q        <= '0;
            nb_q          <= '0;
            abort_pending <= 1'b0;
            core_start    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            issued        <= '0;
            count         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    core_start <= 1'b0;
                    if (go) begin
                        msg_q         <= seed;
                        nb_q          <= nb_messages;
                        keys_q        <= round_keys_in;
                        mask_in_q     <= mask_in;
                        mask_out_q    <= mask_out;
                        issued        <= '0;
                        count         <= '0;
                        aborted       <= 1'b0;
                        abort_pending <= 1'b0;
                        busy          <= 1'b1;
                        if (nb_messages == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            core_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    if (abort) abort_pending <= 1'b1;
                    state <= WAIT;
                end
                // The in-flight result is always scored, even when an abort is pending.
                WAIT: begin
                    if (core_done) begin
                        count  <= count + CNT_W'(hit);
                        issued <= issued + CNT_W'(1);
                        if (last || abort_pending || abort) begin
                            state   <= FINISH;
                            done    <= 1'b1;
                            aborted <= abort_pending | abort;
                        end else begin
                            msg_q      <= next_msg;
                            core_start <= 1'b1;
                            state      <= ISSUE;
                        end
                    end else if (abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                FINISH: begin
                    done          <= 1'b0;
                    busy          <= 1'b0;
                    abort_pending <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
